// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the sequential NxN matrix multiplier.
// Provides the FSM state enum plus index/result width functions.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Index width for an n-entry row/column, never below one bit.
  function automatic int calc_iw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Result width: full product plus headroom for n summed products.
  function automatic int calc_rw(input int dw, input int n);
    return 2 * dw + calc_iw(n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Combinational multiply-accumulate step: {o_cy,o_sum} = {i_cin,i_add} + i_a*i_b.
// Ports: i_a/i_b DW-bit operands, i_add RW-bit addend, i_cin carry in, o_sum RW-bit sum, o_cy carry out.
module matmul_mac #(
  parameter int DW = 8,
  parameter int RW = 17
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [RW-1:0] i_add,
  input  logic          i_cin,
  output logic [RW-1:0] o_sum,
  output logic          o_cy
);

  logic [2*DW-1:0] w_prod;
  logic [RW:0]     w_tot;

  assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};

  // The carry bit keeps the running sum exact across the k loop;
  // the total is bounded below 2^(RW+1), so it never wraps itself.
  assign w_tot = {i_cin, i_add}
               + {{(RW + 1 - 2 * DW){1'b0}}, w_prod};

  assign {o_cy, o_sum} = w_tot;

endmodule

// File: rtl/matrix_multiply_seq.sv
// Sequential NxN unsigned matrix multiplier: C = A*B or C += A*B via one shared MAC.
// Ports: ld_* operand write port, start/acc_mode/busy/done/ovf control, rd_* indexed C read.
module matrix_multiply_seq
  import matmul_pkg::*;
#(
  parameter  int N  = 2,
  parameter  int DW = 8,
  localparam int IW = calc_iw(N),
  localparam int RW = calc_rw(DW, N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [IW-1:0] ld_row,
  input  logic [IW-1:0] ld_col,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  input  logic          acc_mode,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  input  logic [IW-1:0] rd_row,
  input  logic [IW-1:0] rd_col,
  output logic [RW-1:0] rd_data
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW:0]   NV   = (IW + 1)'(N);

  state_t r_state;
  state_t w_next;

  logic [DW-1:0] r_a [N][N];
  logic [DW-1:0] r_b [N][N];
  logic [RW-1:0] r_c [N][N];

  logic [IW-1:0] r_i, r_j, r_k;
  logic [RW-1:0] r_acc;
  logic          r_cy;
  logic          r_accm;
  logic          r_ovf;

  logic          w_first;
  logic          w_last;
  logic          w_ld_ok;
  logic          w_rd_ok;
  logic [RW-1:0] w_add;
  logic          w_cin;
  logic [RW-1:0] w_sum;
  logic          w_cy;

  assign w_first = (r_k == '0);
  assign w_last  = (r_i == LAST) && (r_j == LAST) && (r_k == LAST);
  assign w_ld_ok = ({1'b0, ld_row} < NV) && ({1'b0, ld_col} < NV);
  assign w_rd_ok = ({1'b0, rd_row} < NV) && ({1'b0, rd_col} < NV);

  // k == 0 seeds the sum from C (accumulate) or zero.
  assign w_add = w_first ? (r_accm ? r_c[r_i][r_j] : '0) : r_acc;
  assign w_cin = w_first ? 1'b0 : r_cy;

  matmul_mac #(
    .DW(DW),
    .RW(RW)
  ) u_mac (
    .i_a  (r_a[r_i][r_k]),
    .i_b  (r_b[r_k][r_j]),
    .i_add(w_add),
    .i_cin(w_cin),
    .o_sum(w_sum),
    .o_cy (w_cy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int x = 0; x < N; x++) begin
        for (int y = 0; y < N; y++) begin
          r_a[x][y] <= '0;
          r_b[x][y] <= '0;
          r_c[x][y] <= '0;
        end
      end
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_acc  <= '0;
      r_cy   <= 1'b0;
      r_accm <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (ld_en && w_ld_ok && r_state != CALC) begin
        if (ld_sel) r_b[ld_row][ld_col] <= ld_data;
        else        r_a[ld_row][ld_col] <= ld_data;
      end
      if (r_state == IDLE && start) begin
        r_accm <= acc_mode;
        if (!acc_mode) r_ovf <= 1'b0;
        r_i <= '0;
        r_j <= '0;
        r_k <= '0;
      end
      if (r_state == CALC) begin
        r_acc <= w_sum;
        r_cy  <= w_cy;
        if (w_cy) r_ovf <= 1'b1;
        if (r_k == LAST) begin
          r_c[r_i][r_j] <= w_sum;
          r_k <= '0;
          if (r_j == LAST) begin
            r_j <= '0;
            r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  assign busy    = (r_state == CALC);
  assign done    = (r_state == DONE);
  assign ovf     = r_ovf;
  assign rd_data = w_rd_ok ? r_c[rd_row][rd_col] : '0;

endmodule
